// File: rtl/trx_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trx_link_ctrl
// Description : Queues 4-bit requests and sequences the TRX_top transmitter
//               strobes on tx_clk ticks, then waits for the receiver frame
//               and retries on uncorrectable or timed-out frames. It returns
//               one response per request.
// Revision    : 1.0  initial release
// ============================================================================
module trx_link_ctrl #(
    parameter int DEPTH      = 4,
    parameter int RX_TIMEOUT = 64,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_clk,
    input  logic       req_valid,
    input  logic [3:0] req_data,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    output logic [3:0] tx_data_in,
    output logic       tx_btn1,
    output logic       tx_btn2,
    output logic       tx_load_data,
    output logic       tx_b_ready,
    output logic       tx_t_init,
    input  logic [3:0] rx_data_out,
    input  logic       rx_err_correctable,
    input  logic       rx_err_uncorrectable,
    input  logic       rx_frame_done,
    output logic       rx_not_ready_in,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_status,
    output logic       busy
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_LOAD   = 3'd2,
        S_BREADY = 3'd3,
        S_TINIT  = 3'd4,
        S_WAIT   = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Request FIFO: {mode, data}, pointers carry one extra wrap bit
    logic [5:0]        r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    logic              r_tx_clk_q;
    logic              w_tick;
    logic [c_TW-1:0]   r_tick_cnt;
    logic [2:0]        r_retry_cnt;
    logic [5:0]        r_frame;
    logic [3:0]        r_rsp_data;
    logic [1:0]        r_rsp_status;

    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_retry_clr;
    logic              w_retry_inc;
    logic              w_fail;
    logic              w_rsp_load;
    logic [3:0]        w_rsp_data_nxt;
    logic [1:0]        w_rsp_status_nxt;

    assign w_tick  = tx_clk & ~r_tx_clk_q;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // No bypass: a full FIFO refuses pushes even while it is being popped
    assign w_push  = req_valid && !w_full;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {req_mode, req_data};
        end
    end

    // FIFO pointers and tx_clk edge-detect history
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_clk_q <= 1'b0;
        end else begin
            r_tx_clk_q <= tx_clk;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt      = r_state;
        w_pop            = 1'b0;
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;
        w_retry_clr      = 1'b0;
        w_retry_inc      = 1'b0;
        w_fail           = 1'b0;
        w_rsp_load       = 1'b0;
        w_rsp_data_nxt   = r_rsp_data;
        w_rsp_status_nxt = r_rsp_status;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_retry_clr = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_TW'(1)) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_cnt_inc   = 1'b1;
                    end
                end
            end
            S_LOAD:   if (w_tick) w_state_nxt = S_BREADY;
            S_BREADY: if (w_tick) w_state_nxt = S_TINIT;
            S_TINIT: begin
                if (w_tick) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A received frame wins over a timeout landing in the same clk
                if (rx_frame_done) begin
                    w_rsp_data_nxt = rx_data_out;
                    if (rx_err_uncorrectable) begin
                        w_fail           = 1'b1;
                        w_rsp_status_nxt = 2'b10;
                    end else begin
                        w_rsp_load       = 1'b1;
                        w_rsp_status_nxt = rx_err_correctable ? 2'b01 : 2'b00;
                        w_state_nxt      = S_RESP;
                    end
                end else if (w_tick) begin
                    if (r_tick_cnt == c_TW'(RX_TIMEOUT - 1)) begin
                        w_fail           = 1'b1;
                        w_rsp_data_nxt   = 4'h0;
                        w_rsp_status_nxt = 2'b11;
                    end else begin
                        w_cnt_inc        = 1'b1;
                    end
                end
                if (w_fail) begin
                    if (r_retry_cnt < 3'(MAX_RETRY)) begin
                        w_retry_inc = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_rsp_load  = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame register, counters and response registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_frame      <= '0;
            r_tick_cnt   <= '0;
            r_retry_cnt  <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
        end else begin
            if (w_pop) r_frame <= r_mem[r_rd_ptr[c_AW-1:0]];
            if (w_cnt_clr)      r_tick_cnt <= '0;
            else if (w_cnt_inc) r_tick_cnt <= r_tick_cnt + c_TW'(1);
            if (w_retry_clr)      r_retry_cnt <= '0;
            else if (w_retry_inc) r_retry_cnt <= r_retry_cnt + 3'd1;
            if (w_rsp_load) begin
                r_rsp_data   <= w_rsp_data_nxt;
                r_rsp_status <= w_rsp_status_nxt;
            end
        end
    end

    assign req_ready       = !w_full;
    assign tx_data_in      = r_frame[3:0];
    assign tx_btn1         = r_frame[4];
    assign tx_btn2         = r_frame[5];
    assign tx_load_data    = (r_state == S_LOAD);
    assign tx_b_ready      = (r_state == S_BREADY);
    assign tx_t_init       = (r_state == S_TINIT);
    assign rx_not_ready_in = !((r_state == S_LOAD) || (r_state == S_BREADY) ||
                               (r_state == S_TINIT) || (r_state == S_WAIT));
    assign rsp_valid       = (r_state == S_RESP);
    assign rsp_data        = r_rsp_data;
    assign rsp_status      = r_rsp_status;
    assign busy            = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire
